// File: rtl/interrupt_ctrl_pkg.sv
// interrupt_ctrl_pkg: CLINT address map, mip bit positions, interrupt cause and FSM encodings
package interrupt_ctrl_pkg;
    localparam logic [31:0] CLINT_MSIP     = 32'h0200_0000;
    localparam logic [31:0] CLINT_MTIMECMP = 32'h0200_4000;
    localparam logic [31:0] CLINT_MTIME    = 32'h0200_BFF8;
    localparam int MIP_MEIP = 11;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MSIP = 3;
    typedef enum logic [1:0] {NOINT = 2'd0, EXINT = 2'd1, SWINT = 2'd2, TRINT = 2'd3} m_interrupt;
    typedef logic [1:0] irq_state_t;
    localparam irq_state_t IDLE = 2'd0;
    localparam irq_state_t REQ  = 2'd1;
    localparam irq_state_t HOLD = 2'd2;
    function automatic logic [63:0] byte_merge(input logic [63:0] old, input logic [63:0] din,
                                               input logic [7:0] strb);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = strb[i] ? din[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/interrupt_ctrl_sync.sv
// irq_sync: multi-flop synchroniser for the asynchronous external interrupt line
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk or posedge reset)
        if (reset) ff <= '0;
        else ff <= {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: CLINT-style timer/software/external interrupt sources with MMIO and a
// single arbitrated, acknowledge-handshaked request towards csr.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int TIMER_DIV   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_irq,
    input  logic [63:0] csr_mie,
    input  logic        csr_gie,
    input  logic        irq_ack,
    input  logic        mmio_req,
    input  logic        mmio_we,
    input  logic [31:0] mmio_addr,
    input  logic [7:0]  mmio_strb,
    input  logic [63:0] mmio_wdata,
    output logic [63:0] mmio_rdata,
    output logic        mmio_hit,
    output logic        irq_valid,
    output logic [1:0]  irq_cause,
    output logic [63:0] mip
);
    localparam int PW = $clog2(TIMER_DIV + 1);
    logic [PW-1:0] presc;
    logic [63:0] mtime, mtimecmp;
    logic msip, meip, mtip, tick, wr;
    logic sel_msip, sel_cmp, sel_time;
    logic e_ext, e_sw, e_tm, still;
    logic [1:0] best;
    irq_state_t state;
    logic unused_bits;

    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .reset(reset), .d(ext_irq), .q(meip));

    assign sel_msip = mmio_addr[31:3] == CLINT_MSIP[31:3];
    assign sel_cmp  = mmio_addr[31:3] == CLINT_MTIMECMP[31:3];
    assign sel_time = mmio_addr[31:3] == CLINT_MTIME[31:3];
    assign mmio_hit = mmio_req & (sel_msip | sel_cmp | sel_time);
    assign wr       = mmio_req & mmio_we;
    assign tick     = presc == PW'(TIMER_DIV - 1);
    assign mmio_rdata = !mmio_req ? 64'd0 : sel_msip ? {63'd0, msip} : sel_cmp ? mtimecmp :
                        sel_time ? mtime : 64'd0;
    assign unused_bits = ^{csr_mie[63:12], csr_mie[10:8], csr_mie[6:4], csr_mie[2:0], mmio_addr[2:0]};

    // A software write to mtime takes precedence over that cycle's increment.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            presc    <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            presc    <= tick ? '0 : presc + PW'(1);
            mtime    <= (wr & sel_time) ? byte_merge(mtime, mmio_wdata, mmio_strb) :
                        tick ? mtime + 64'd1 : mtime;
            mtimecmp <= (wr & sel_cmp) ? byte_merge(mtimecmp, mmio_wdata, mmio_strb) : mtimecmp;
            msip     <= (wr & sel_msip & mmio_strb[0]) ? mmio_wdata[0] : msip;
        end

    assign mtip  = mtime >= mtimecmp;
    assign e_ext = csr_gie & csr_mie[MIP_MEIP] & meip;
    assign e_sw  = csr_gie & csr_mie[MIP_MSIP] & msip;
    assign e_tm  = csr_gie & csr_mie[MIP_MTIP] & mtip;
    assign best  = e_ext ? EXINT : e_sw ? SWINT : e_tm ? TRINT : NOINT;
    assign still = irq_cause == EXINT ? e_ext : irq_cause == SWINT ? e_sw :
                   irq_cause == TRINT ? e_tm : 1'b0;

    always_comb begin
        mip = '0;
        mip[MIP_MEIP] = meip;
        mip[MIP_MTIP] = mtip;
        mip[MIP_MSIP] = msip;
    end

    // Cause is frozen while a request is outstanding; ack beats withdraw.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_cause <= NOINT;
        end else if (state == IDLE) begin
            if (best != NOINT) begin
                state     <= REQ;
                irq_valid <= 1'b1;
                irq_cause <= best;
            end
        end else if (state == REQ) begin
            if (irq_ack | !still) begin
                state     <= irq_ack ? HOLD : IDLE;
                irq_valid <= 1'b0;
            end
        end else begin
            state     <= IDLE;
            irq_valid <= 1'b0;
        end
endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb_interrupt_ctrl: table-driven MMIO vectors plus directed interrupt sequences
module tb_interrupt_ctrl;
    import interrupt_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset, ext_irq, csr_gie, irq_ack, mmio_req, mmio_we;
    logic [63:0] csr_mie, mmio_wdata, mmio_rdata, mip;
    logic [31:0] mmio_addr;
    logic [7:0]  mmio_strb;
    logic        mmio_hit, irq_valid;
    logic [1:0]  irq_cause;
    int total = 0, bad = 0;

    interrupt_ctrl dut (
        .clk(clk), .reset(reset), .ext_irq(ext_irq), .csr_mie(csr_mie), .csr_gie(csr_gie),
        .irq_ack(irq_ack), .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
        .mmio_strb(mmio_strb), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
        .mmio_hit(mmio_hit), .irq_valid(irq_valid), .irq_cause(irq_cause), .mip(mip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        hit;
        logic [63:0] mip;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d);
        mmio_req = 1'b1; mmio_we = 1'b1; mmio_addr = a; mmio_strb = s; mmio_wdata = d;
        step();
        mmio_req = 1'b0; mmio_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [63:0] d, output logic h);
        mmio_req = 1'b1; mmio_we = 1'b0; mmio_addr = a;
        #1;
        d = mmio_rdata; h = mmio_hit;
        mmio_req = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        logic h;
        int n;
        tbl[0]  = '{1'b1, CLINT_MTIMECMP, 8'hFF, 64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0};
        tbl[1]  = '{1'b0, CLINT_MTIMECMP, 8'h00, 64'h0, 64'h1111_2222_3333_4444, 1'b1, 64'h0};
        tbl[2]  = '{1'b1, CLINT_MTIMECMP, 8'hF0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b1, 64'h0};
        tbl[3]  = '{1'b0, CLINT_MTIMECMP, 8'h00, 64'h0, 64'hAAAA_BBBB_3333_4444, 1'b1, 64'h0};
        tbl[4]  = '{1'b1, CLINT_MSIP, 8'h01, 64'hFFFF_FFFF, 64'h0, 1'b1, 64'h0};
        tbl[5]  = '{1'b0, CLINT_MSIP, 8'h00, 64'h0, 64'h1, 1'b1, 64'h8};
        tbl[6]  = '{1'b1, CLINT_MSIP, 8'h00, 64'h0, 64'h1, 1'b1, 64'h8};
        tbl[7]  = '{1'b0, CLINT_MSIP, 8'h00, 64'h0, 64'h1, 1'b1, 64'h8};
        tbl[8]  = '{1'b1, CLINT_MSIP, 8'h01, 64'h0, 64'h1, 1'b1, 64'h8};
        tbl[9]  = '{1'b0, CLINT_MSIP, 8'h00, 64'h0, 64'h0, 1'b1, 64'h0};
        tbl[10] = '{1'b0, 32'h0200_1000, 8'h00, 64'h0, 64'h0, 1'b0, 64'h0};
        tbl[11] = '{1'b1, 32'h0200_1000, 8'hFF, 64'h5555_5555_5555_5555, 64'h0, 1'b0, 64'h0};
        tbl[12] = '{1'b0, 32'h0200_0004, 8'h00, 64'h0, 64'h0, 1'b1, 64'h0};
        tbl[13] = '{1'b0, 32'h0200_4008, 8'h00, 64'h0, 64'h0, 1'b0, 64'h0};
        tbl[14] = '{1'b0, CLINT_MTIMECMP, 8'h00, 64'h0, 64'hAAAA_BBBB_3333_4444, 1'b1, 64'h0};

        reset = 1'b1; ext_irq = 1'b0; csr_mie = '0; csr_gie = 1'b0; irq_ack = 1'b0;
        mmio_req = 1'b0; mmio_we = 1'b0; mmio_addr = '0; mmio_strb = '0; mmio_wdata = '0;
        #1;
        chk("rst_valid", {63'd0, irq_valid}, 64'd0);
        chk("rst_cause", {62'd0, irq_cause}, 64'd0);
        chk("rst_mip", mip, 64'd0);
        chk("rst_rdata_idle", mmio_rdata, 64'd0);
        rd(CLINT_MTIMECMP, d, h); chk("rst_mtimecmp", d, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(CLINT_MTIME, d, h);    chk("rst_mtime", d, 64'd0);
        step(); step();
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            mmio_req = 1'b1; mmio_we = tbl[i].we; mmio_addr = tbl[i].addr;
            mmio_strb = tbl[i].strb; mmio_wdata = tbl[i].wdata;
            #1;
            chk($sformatf("tbl%0d_rdata", i), mmio_rdata, tbl[i].rdata);
            chk($sformatf("tbl%0d_hit", i), {63'd0, mmio_hit}, {63'd0, tbl[i].hit});
            chk($sformatf("tbl%0d_mip", i), mip, tbl[i].mip);
            step();
        end
        mmio_req = 1'b0; mmio_we = 1'b0;

        wr(CLINT_MTIME, 8'h0F, 64'h1234);
        rd(CLINT_MTIME, d, h); chk("mtime_strb", d, 64'h1234); chk("mtime_hit", {63'd0, h}, 64'd1);
        step();
        rd(CLINT_MTIME, d, h); chk("mtime_inc", d, 64'h1235);
        wr(CLINT_MTIME, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(CLINT_MTIME, d, h); chk("mtime_max", d, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mtip_at_max", mip, 64'h80);
        chk("no_irq_mie0", {63'd0, irq_valid}, 64'd0);
        step();
        rd(CLINT_MTIME, d, h); chk("mtime_wrap", d, 64'd0);

        csr_mie = 64'h80; csr_gie = 1'b1;
        wr(CLINT_MTIME, 8'hFF, 64'd0);
        wr(CLINT_MTIMECMP, 8'hFF, 64'd20);
        n = 0;
        while (!irq_valid && n < 40) begin step(); n++; end
        chk("timer_cycles", 64'(n), 64'd20);
        chk("timer_cause", {62'd0, irq_cause}, {62'd0, TRINT});
        ack();
        chk("ack_drop", {63'd0, irq_valid}, 64'd0);
        step(); chk("hold_idle", {63'd0, irq_valid}, 64'd0);
        step(); chk("rereq", {63'd0, irq_valid}, 64'd1);
        wr(CLINT_MTIMECMP, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        step(); chk("cmp_withdraw", {63'd0, irq_valid}, 64'd0);

        wr(CLINT_MTIMECMP, 8'hFF, 64'd0);
        chk("lat1_valid", {63'd0, irq_valid}, 64'd0);
        chk("lat1_mip", mip, 64'h80);
        step(); chk("lat2_valid", {63'd0, irq_valid}, 64'd1);
        ack();
        csr_gie = 1'b0;
        step(); step(); step();
        chk("gate_gie", {63'd0, irq_valid}, 64'd0);
        chk("gate_gie_mip", mip, 64'h80);
        csr_gie = 1'b1; csr_mie = 64'h0;
        step(); step(); step();
        chk("gate_mie", {63'd0, irq_valid}, 64'd0);
        csr_mie = 64'h80;
        step(); chk("enable_req", {63'd0, irq_valid}, 64'd1);
        ack();

        csr_gie = 1'b0; csr_mie = 64'h888; ext_irq = 1'b1;
        wr(CLINT_MSIP, 8'h01, 64'd1);
        step(); step();
        chk("prio_mip", mip, 64'h888);
        csr_gie = 1'b1;
        step();
        chk("prio_valid", {63'd0, irq_valid}, 64'd1);
        chk("prio_cause", {62'd0, irq_cause}, {62'd0, EXINT});
        ext_irq = 1'b0;
        ack();
        chk("prio_ack", {63'd0, irq_valid}, 64'd0);
        n = 0;
        while (!irq_valid && n < 10) begin step(); n++; end
        chk("next_valid", {63'd0, irq_valid}, 64'd1);
        chk("next_cause", {62'd0, irq_cause}, {62'd0, SWINT});

        wr(CLINT_MSIP, 8'h01, 64'd0);
        chk("wd_still", {63'd0, irq_valid}, 64'd1);
        step(); chk("withdraw", {63'd0, irq_valid}, 64'd0);
        step();
        chk("after_wd_valid", {63'd0, irq_valid}, 64'd1);
        chk("after_wd_cause", {62'd0, irq_cause}, {62'd0, TRINT});
        ext_irq = 1'b1;
        step(); step(); step(); step();
        chk("no_preempt_valid", {63'd0, irq_valid}, 64'd1);
        chk("no_preempt_cause", {62'd0, irq_cause}, {62'd0, TRINT});

        csr_gie = 1'b0;
        ack();
        csr_gie = 1'b1;
        chk("ackwd_drop", {63'd0, irq_valid}, 64'd0);
        step(); chk("ack_wins_hold", {63'd0, irq_valid}, 64'd0);
        step();
        chk("ackwd_rereq", {63'd0, irq_valid}, 64'd1);
        chk("ackwd_cause", {62'd0, irq_cause}, {62'd0, EXINT});

        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", {63'd0, irq_valid}, 64'd0);
        chk("async_rst_cause", {62'd0, irq_cause}, 64'd0);
        chk("async_rst_mip", mip, 64'd0);
        rd(CLINT_MTIMECMP, d, h); chk("async_rst_cmp", d, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(CLINT_MTIME, d, h);    chk("async_rst_mtime", d, 64'd0);
        step();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
